// File: rtl/photon_hls_dl_pkg.sv
// ---------------------------------------------------------------------------
// photon_hls_dl_pkg
// Shared types and helpers for the photon HLS deadlock report unit.
//   dl_rpt_state_t : report collector FSM states
//   dl_report_t    : deadlock report record, sized for up to DL_MAX_PROC units
//   dl_clog2()     : ceil(log2(n)), never less than 1 (usable as a port width)
//   dl_onehot()    : one-hot vector with bit idx set, DL_MAX_PROC bits wide
// ---------------------------------------------------------------------------
package photon_hls_dl_pkg;

    localparam int DL_MAX_PROC  = 32;
    localparam int DL_IDX_W_MAX = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACE,
        ST_REPORT,
        ST_HALT
    } dl_rpt_state_t;

    typedef struct packed {
        logic [DL_IDX_W_MAX-1:0] origin;
        logic [DL_MAX_PROC-1:0]  mask;
        logic [DL_IDX_W_MAX:0]   hops;
        logic                    timeout;
    } dl_report_t;

    function automatic int dl_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic [DL_MAX_PROC-1:0] dl_onehot(input int idx);
        return DL_MAX_PROC'(1) << idx;
    endfunction

endpackage

// File: rtl/photon_hls_dl_prio_enc.sv
// ---------------------------------------------------------------------------
// photon_hls_dl_prio_enc
// Lowest-set-bit priority encoder used to elect the deadlock origin.
//   req   in  WIDTH : request vector
//   idx   out IDX_W : index of the lowest set bit (0 when none set)
//   valid out 1     : at least one request bit is set
// ---------------------------------------------------------------------------
module photon_hls_dl_prio_enc
    import photon_hls_dl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = dl_clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan from the top down so the lowest set bit is the last writer.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/photon_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// photon_hls_deadlock_report_unit
// Central collector for the per-process deadlock detect units. Elects the
// lowest-index detecting unit as origin, pulses its origin input, raises the
// global detect broadcast, follows the token back to the origin, clears it,
// and presents a one-shot report over a valid/ready handshake. HALT is
// terminal until reset.
//
// Ports:
//   clock            in  1          rising-edge clock
//   reset            in  1          asynchronous, active-low reset
//   dl_in_vec        in  PROC_NUM   per-unit dl_detect_out
//   dl_detect_out    out 1          global detect broadcast
//   origin_vec       out PROC_NUM   one-cycle one-hot origin pulse
//   token_clear_vec  out PROC_NUM   combinational token clear at return
//   report_valid     out 1          report available
//   report_ready     in  1          consumer accepts report
//   report_origin    out clog2(P)   elected origin index
//   report_mask      out PROC_NUM   units seen detecting during the trace
//   report_hops      out clog2(P+1) non-origin trace cycles, saturating
//   report_timeout   out 1          trace ended by timeout
//
// Optional feature: define PHOTON_DL_TIMEOUT_EN to end a trace after
// TIMEOUT_CYCLES cycles without token return. Otherwise TRACE waits forever
// and report_timeout stays 0.
// ---------------------------------------------------------------------------
module photon_hls_deadlock_report_unit
    import photon_hls_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [PROC_NUM-1:0]              dl_in_vec,
    output logic                             dl_detect_out,
    output logic [PROC_NUM-1:0]              origin_vec,
    output logic [PROC_NUM-1:0]              token_clear_vec,
    output logic                             report_valid,
    input  logic                             report_ready,
    output logic [dl_clog2(PROC_NUM)-1:0]    report_origin,
    output logic [PROC_NUM-1:0]              report_mask,
    output logic [dl_clog2(PROC_NUM+1)-1:0]  report_hops,
    output logic                             report_timeout
);

    localparam int                IDX_W   = dl_clog2(PROC_NUM);
    localparam int                HOP_W   = dl_clog2(PROC_NUM + 1);
    localparam logic [HOP_W-1:0]  HOP_MAX = HOP_W'(PROC_NUM);

    dl_rpt_state_t       state, state_nx;
    logic                first;
    logic [IDX_W-1:0]    elect_idx;
    logic                elect_vld;
    logic [PROC_NUM-1:0] elect_oh;
    logic [PROC_NUM-1:0] origin_oh;
    logic                hop_seen;
    logic                token_ret;
    logic                timed_out;

    photon_hls_dl_prio_enc #(
        .WIDTH (PROC_NUM),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (dl_in_vec),
        .idx   (elect_idx),
        .valid (elect_vld)
    );

    assign elect_oh  = PROC_NUM'(dl_onehot(int'(elect_idx)));
    // report_origin holds the elected index from election onwards.
    assign origin_oh = PROC_NUM'(dl_onehot(int'(report_origin)));
    assign hop_seen  = |(dl_in_vec & ~origin_oh);
    // The origin's own detect bit is still up in the first TRACE cycle, so
    // it only counts as a returning token once first has cleared.
    assign token_ret = (state == ST_TRACE) && !first && |(dl_in_vec & origin_oh);

`ifdef PHOTON_DL_TIMEOUT_EN
    localparam int CNT_W = dl_clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] trace_cnt;

    // Counter sits at zero outside TRACE, so it restarts on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trace_cnt <= '0;
        end else if (state != ST_TRACE) begin
            trace_cnt <= '0;
        end else begin
            trace_cnt <= trace_cnt + CNT_W'(1);
        end
    end

    assign timed_out = (state == ST_TRACE) && (trace_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        token_clear_vec = '0;
        case (state)
            ST_IDLE: begin
                if (elect_vld) state_nx = ST_TRACE;
            end
            ST_TRACE: begin
                // Token return takes priority over a coincident timeout.
                if (token_ret) begin
                    token_clear_vec = origin_oh;
                    state_nx        = ST_REPORT;
                end else if (timed_out) begin
                    state_nx = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (report_ready) state_nx = ST_HALT;
            end
            ST_HALT: begin
                state_nx = ST_HALT;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dl_detect_out  <= 1'b0;
            origin_vec     <= '0;
            report_valid   <= 1'b0;
            report_origin  <= '0;
            report_mask    <= '0;
            report_hops    <= '0;
            report_timeout <= 1'b0;
            first          <= 1'b0;
        end else begin
            origin_vec <= '0;
            case (state)
                ST_IDLE: begin
                    if (elect_vld) begin
                        report_origin  <= elect_idx;
                        origin_vec     <= elect_oh;
                        dl_detect_out  <= 1'b1;
                        report_mask    <= elect_oh;
                        report_hops    <= '0;
                        report_timeout <= 1'b0;
                        first          <= 1'b1;
                    end
                end
                ST_TRACE: begin
                    first       <= 1'b0;
                    report_mask <= report_mask | dl_in_vec;
                    if (hop_seen && (report_hops != HOP_MAX)) begin
                        report_hops <= report_hops + HOP_W'(1);
                    end
                    if (token_ret || timed_out) begin
                        report_valid   <= 1'b1;
                        report_timeout <= !token_ret;
                    end
                end
                ST_REPORT: begin
                    if (report_ready) report_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_photon_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// tb_photon_hls_deadlock_report_unit
// Directed bench for the deadlock report unit (PROC_NUM=4, TIMEOUT_CYCLES=8).
// A transaction-level model predicts every output; a negedge process compares
// the DUT against it each cycle, and literal checks pin the model on the
// hand-computed scenarios. PHOTON_DL_TIMEOUT_EN selects the timeout scenario.
// ---------------------------------------------------------------------------
module tb_photon_hls_deadlock_report_unit;
    import photon_hls_dl_pkg::*;

    localparam int P  = 4;
    localparam int TO = 8;

    logic         clock;
    logic         reset;
    logic [P-1:0] dl_in_vec;
    logic         dl_detect_out;
    logic [P-1:0] origin_vec;
    logic [P-1:0] token_clear_vec;
    logic         report_valid;
    logic         report_ready;
    logic [1:0]   report_origin;
    logic [P-1:0] report_mask;
    logic [2:0]   report_hops;
    logic         report_timeout;

    int n_checks = 0;
    int n_err    = 0;

    photon_hls_deadlock_report_unit #(
        .PROC_NUM       (P),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dl_in_vec       (dl_in_vec),
        .dl_detect_out   (dl_detect_out),
        .origin_vec      (origin_vec),
        .token_clear_vec (token_clear_vec),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_origin   (report_origin),
        .report_mask     (report_mask),
        .report_hops     (report_hops),
        .report_timeout  (report_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the trace as a transaction: has a detection happened, how many
    // trace cycles have elapsed, was the report produced, was it taken.
    logic       m_active, m_reported, m_accepted;
    int         m_tlen;
    logic [P-1:0] m_pulse;
    dl_report_t m_rpt;

    function automatic logic [P-1:0] model_clear(input logic [P-1:0] din);
        if (m_active && !m_reported && m_tlen >= 1 && din[m_rpt.origin])
            return P'(1) << m_rpt.origin;
        return '0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_reported = 0; m_accepted = 0;
            m_tlen = 0; m_pulse = '0; m_rpt = '0;
        end else begin
            m_pulse = '0;
            if (!m_active) begin
                for (int i = 0; i < P; i++) begin
                    if (dl_in_vec[i]) begin
                        m_active   = 1;
                        m_rpt      = '0;
                        m_rpt.origin = 5'(i);
                        m_rpt.mask = 32'(1) << i;
                        m_pulse    = P'(1) << i;
                        m_tlen     = 0;
                        break;
                    end
                end
            end else if (!m_reported) begin
                logic ret;
                ret = (m_tlen >= 1) && dl_in_vec[m_rpt.origin];
                m_tlen++;
                m_rpt.mask = m_rpt.mask | 32'(dl_in_vec);
                if ((dl_in_vec & ~(P'(1) << m_rpt.origin)) != 0 && m_rpt.hops < P)
                    m_rpt.hops = m_rpt.hops + 1;
                if (ret) begin
                    m_reported = 1; m_rpt.timeout = 0;
                end
`ifdef PHOTON_DL_TIMEOUT_EN
                else if (m_tlen == TO) begin
                    m_reported = 1; m_rpt.timeout = 1;
                end
`endif
            end else if (!m_accepted) begin
                if (report_ready) m_accepted = 1;
            end
        end
    end

    always @(negedge clock) begin
        check("cmp_detect", 32'(dl_detect_out), 32'(m_active));
        check("cmp_origin_vec", 32'(origin_vec), 32'(m_pulse));
        check("cmp_token_clear", 32'(token_clear_vec), 32'(model_clear(dl_in_vec)));
        check("cmp_valid", 32'(report_valid), 32'(m_reported && !m_accepted));
        check("cmp_origin", 32'(report_origin), 32'(m_rpt.origin));
        check("cmp_mask", 32'(report_mask), m_rpt.mask);
        check("cmp_hops", 32'(report_hops), 32'(m_rpt.hops));
        check("cmp_timeout", 32'(report_timeout), 32'(m_rpt.timeout));
    end

    // ---------------- stimulus ----------------
    // Wait for an edge, apply new inputs, let them settle; outputs then show
    // the result of the previous inputs, token_clear_vec reflects the new ones.
    task automatic step(input logic [P-1:0] v, input logic rdy);
        @(posedge clock);
        #1;
        dl_in_vec    = v;
        report_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step('0, 1'b0);
        step('0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        dl_in_vec    = '0;
        report_ready = 1'b0;
        step('0, 1'b0);
        check("rst_detect", 32'(dl_detect_out), 32'd0);
        check("rst_valid", 32'(report_valid), 32'd0);
        check("rst_fields", {report_origin, report_mask, report_hops, report_timeout}, 32'd0);
        do_reset();

        // Origin 2; bits 3, 0, 2 in consecutive TRACE cycles.
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        check("elect_pulse", 32'(origin_vec), 32'b0100);
        check("elect_detect", 32'(dl_detect_out), 32'd1);
        step(4'b0001, 1'b0);
        check("pulse_one_cycle", 32'(origin_vec), 32'd0);
        step(4'b0100, 1'b0);
        check("return_clear", 32'(token_clear_vec), 32'b0100);
        step(4'b0000, 1'b0);
        check("rpt_valid", 32'(report_valid), 32'd1);
        check("rpt_mask", 32'(report_mask), 32'b1101);
        check("rpt_hops", 32'(report_hops), 32'd2);
        check("rpt_timeout", 32'(report_timeout), 32'd0);
        check("rpt_origin", 32'(report_origin), 32'd2);
        check("rpt_clear_gone", 32'(token_clear_vec), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0);
            check("stall_valid", 32'(report_valid), 32'd1);
            check("stall_mask", 32'(report_mask), 32'b1101);
        end
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        check("halt_valid", 32'(report_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1);
            check("halt_origin_vec", 32'(origin_vec), 32'd0);
            check("halt_clear", 32'(token_clear_vec), 32'd0);
            check("halt_detect", 32'(dl_detect_out), 32'd1);
            check("halt_mask", 32'(report_mask), 32'b1101);
        end

        // Simultaneous detect, ready ignored outside REPORT, reset mid-TRACE.
        do_reset();
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b1);
        check("simul_pulse", 32'(origin_vec), 32'b0010);
        check("simul_origin", 32'(report_origin), 32'd1);
        check("simul_mask", 32'(report_mask), 32'b0010);
        step(4'b1000, 1'b1);
        step(4'b0010, 1'b1);
        check("pre_rst_clear", 32'(token_clear_vec), 32'b0010);
        reset = 1'b0;
        #1;
        check("async_detect", 32'(dl_detect_out), 32'd0);
        check("async_clear", 32'(token_clear_vec), 32'd0);
        check("async_fields", {report_valid, origin_vec, report_origin, report_mask,
                               report_hops, report_timeout}, 32'd0);
        dl_in_vec = '0;
        step(4'b0000, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0);
        check("reelect_pulse", 32'(origin_vec), 32'b1000);
        check("reelect_origin", 32'(report_origin), 32'd3);
        step(4'b1000, 1'b0);
        check("reelect_clear", 32'(token_clear_vec), 32'b1000);
        step(4'b0000, 1'b1);
        check("reelect_valid", 32'(report_valid), 32'd1);
        check("reelect_mask", 32'(report_mask), 32'b1001);
        check("reelect_hops", 32'(report_hops), 32'd1);
        step(4'b0000, 1'b0);
        check("reelect_halt", 32'(report_valid), 32'd0);

        // Long trace without return; hop count saturates at PROC_NUM.
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b1110, 1'b0);
        check("long_pulse", 32'(origin_vec), 32'b0001);
`ifdef PHOTON_DL_TIMEOUT_EN
        for (int i = 1; i < TO; i++) step(4'b1110, 1'b0);
        check("to_not_yet", 32'(report_valid), 32'd0);
        step(4'b0000, 1'b0);
        check("to_valid", 32'(report_valid), 32'd1);
        check("to_flag", 32'(report_timeout), 32'd1);
        check("to_hops_sat", 32'(report_hops), 32'd4);
        check("to_mask", 32'(report_mask), 32'b1111);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        check("to_halt", 32'(report_valid), 32'd0);
`else
        for (int i = 0; i < 20; i++) step(4'b1110, 1'b0);
        check("wait_no_valid", 32'(report_valid), 32'd0);
        check("wait_hops_sat", 32'(report_hops), 32'd4);
        step(4'b0001, 1'b0);
        check("wait_clear", 32'(token_clear_vec), 32'b0001);
        step(4'b0000, 1'b1);
        check("wait_valid", 32'(report_valid), 32'd1);
        check("wait_timeout", 32'(report_timeout), 32'd0);
        check("wait_mask", 32'(report_mask), 32'b1111);
        check("wait_hops", 32'(report_hops), 32'd4);
        step(4'b0000, 1'b0);
        check("wait_halt", 32'(report_valid), 32'd0);
`endif

        step(4'b0000, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/photon_hls_deadlock_report_unit.md
# photon_hls_deadlock_report_unit

Central collector for the per-process deadlock detect units in the photon HLS dataflow region. Watches every unit's local `dl_detect_out`, elects one originating process, and drives that unit's `origin` pulse plus the global `dl_detect_in` broadcast. Follows the circulating token back to the origin, issues `token_clear`, and presents a one-shot deadlock report (participant mask, hop count, optional timeout flag) over a valid/ready handshake.

## Interface
- `PROC_NUM`, 4: number of dataflow processes / detect units.
- `TIMEOUT_CYCLES`, 1024: trace timeout in cycles, only used under the timeout macro; must be ≥ 2.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `dl_in_vec`  in  PROC_NUM: bit p = `dl_detect_out` of detect unit p.
- `dl_detect_out`  out  1: global detect flag, broadcast to every unit's `dl_detect_in`.
- `origin_vec`  out  PROC_NUM: one-hot, one-cycle pulse to the elected unit's `origin`.
- `token_clear_vec`  out  PROC_NUM: combinational, to each unit's `token_clear`.
- `report_valid`  out  1: report available.
- `report_ready`  in  1: consumer accepts report.
- `report_origin`  out  $clog2(PROC_NUM): elected origin index.
- `report_mask`  out  PROC_NUM: processes seen asserting `dl_in_vec` during the trace, origin included.
- `report_hops`  out  $clog2(PROC_NUM+1): trace cycles with a non-origin bit set, saturating at PROC_NUM.
- `report_timeout`  out  1: trace ended by timeout, not by token return.

## Operation
- FSM states: IDLE, TRACE, REPORT, HALT. Reset → IDLE.
- **IDLE.** `dl_detect_out`=0. On an edge with `|dl_in_vec`:
  - `origin_id` ← lowest set index.
  - `origin_vec` ← onehot(`origin_id`) for exactly one cycle.
  - `dl_detect_out` ← 1; `report_mask` ← onehot(`origin_id`); hop count ← 0; `first` ← 1; go to TRACE.
- **TRACE.**
  - Each cycle: `report_mask` |= `dl_in_vec`.
  - If `dl_in_vec` & ~onehot(`origin_id`) is nonzero: hop count +1, saturating at PROC_NUM.
  - `first` clears after the first TRACE cycle. The origin bit is ignored while `first`=1.
- **Token return.** In TRACE with `first`=0 and `dl_in_vec[origin_id]`=1:
  - `token_clear_vec[origin_id]`=1 combinationally in that same cycle. All other bits are always 0.
  - Next state REPORT; `report_timeout` ← 0.
- **REPORT.**
  - `report_valid`=1; all `report_*` fields are stable.
  - On `report_valid & report_ready` → HALT, and `report_valid` drops the next cycle.
- **HALT.** Terminal state.
  - `dl_detect_out` stays 1 and `report_*` fields hold.
  - `dl_in_vec` is ignored; exit only by reset.
- **Simultaneous detections in IDLE:** lowest index wins. Other bits are not recorded at election; they enter the mask only if they reassert in TRACE.
- **`report_ready` outside REPORT:** ignored.
- **Reset mid-operation:** any state → IDLE immediately; all outputs go to reset values asynchronously.

## Timing
- Reset values:
  - `dl_detect_out`, `origin_vec`, `token_clear_vec`, `report_valid`, `report_timeout` = 0.
  - `report_origin`, `report_mask`, `report_hops` = 0.
- Detection → `origin_vec` pulse and `dl_detect_out` rise: 1 cycle, registered.
- Token return → `token_clear_vec`: 0 cycles, combinational from `dl_in_vec` and state.
- Token return → `report_valid`: 1 cycle.
- All outputs except `token_clear_vec` are registered.

## Configuration
- `PHOTON_DL_TIMEOUT_EN` defined:
  - A TRACE cycle counter resets on TRACE entry and counts each TRACE cycle.
  - On reaching TIMEOUT_CYCLES without token return: go to REPORT with `report_timeout`=1 and no `token_clear_vec` pulse.
  - If token return and timeout land on the same cycle, token return wins.
- Undefined: no counter; TRACE waits indefinitely; `report_timeout` is constant 0.

## Structure
- Shared package `photon_hls_dl_pkg`: state enum `dl_rpt_state_t`, onehot/clog2 helper functions, report struct typedef.
- One sub-module, `photon_hls_dl_prio_enc`: parameterized lowest-set-bit encoder (index + valid), used for origin election.

## Test plan
- PROC_NUM=4, `dl_in_vec`=4'b0100 for 1 cycle at t0 → `origin_vec`=4'b0100 pulse at t0+1, `dl_detect_out`=1 from t0+1.
- Simultaneous `dl_in_vec`=4'b1010 in IDLE → `report_origin`=1, `origin_vec`=4'b0010.
- Origin 2, then bits 3, 0, 2 in consecutive TRACE cycles:
  - Same cycle as bit 2: `token_clear_vec`=4'b0100.
  - Next cycle: `report_valid`=1, mask=4'b1101, hops=2, timeout=0.
- `report_ready` held 0 for 5 cycles → `report_valid` stays 1, fields stable. Ready=1 → HALT; further `dl_in_vec` activity produces no outputs.
- With `PHOTON_DL_TIMEOUT_EN`, TIMEOUT_CYCLES=8, no return → REPORT after 8 TRACE cycles with `report_timeout`=1 and no `token_clear_vec` pulse.
- Assert `reset`=0 mid-TRACE → all outputs 0 immediately. After release, a new detection elects afresh.
